// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: segment patterns, scan phases, polarity helpers.
// Patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the output registers.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  localparam logic PHASE_BLANK = 1'b0;
  localparam logic PHASE_ON    = 1'b1;

  localparam bit POL_ACTIVE_HIGH = 1'b0;
  localparam bit POL_ACTIVE_LOW  = 1'b1;

  function automatic logic [6:0] apply_pol(input logic [6:0] lit, input bit active_low);
    return (active_low == POL_ACTIVE_LOW) ? ~lit : lit;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment pattern; 10..15 render as a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_disp_scan.sv
// Multiplexed BCD display scanner: one-entry shadow buffer committed at frame boundaries, blanked slot lead-in.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module bcd_disp_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RES,
  input  logic [4*DIGITS-1:0]   BCD_IN,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic                  LOAD_VALID,
  output logic                  LOAD_READY,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [DIGITS-1:0]     COM,
  output logic                  BCD_ERR
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] COM_OFF = COM_ACTIVE_LOW ? '1 : '0;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  full;
  logic [4*DIGITS-1:0]   sh_bcd, disp_bcd;
  logic [DIGITS-1:0]     sh_dp, disp_dp;

  logic cnt_wrap, idx_wrap, frame_end, accept, commit, sh_bad, phase, sel_blank;
  logic [3:0]        cur_digit;
  logic [6:0]        dec_seg;
  logic [DIGITS-1:0] com_onehot;

  assign cnt_wrap   = (cnt == CW'(SCAN_DIV - 1));
  assign idx_wrap   = (idx == IW'(DIGITS - 1));
  assign frame_end  = cnt_wrap && idx_wrap;
  assign LOAD_READY = !full;
  assign accept     = LOAD_VALID && !full;
  assign commit     = frame_end && full;
  assign phase      = (cnt < CW'(BLANK_CYC)) ? PHASE_BLANK : PHASE_ON;
  assign cur_digit  = disp_bcd[4*int'(idx) +: 4];
  assign com_onehot = DIGITS'(1) << idx;

  always_comb begin
    sh_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_bcd[4*i +: 4] > 4'd9) sh_bad = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_blank;
  logic              upper_zero;

  // Walk down from the top digit; a digit blanks only while everything from it upward is zero.
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (disp_bcd[4*i +: 4] == 4'd0);
      lz_blank[i] = upper_zero && !disp_dp[i];
    end
  end

  assign sel_blank = lz_blank[idx];
`else
  assign sel_blank = 1'b0;
`endif

  seg7_decode u_dec (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= idx_wrap ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Commit and accept are exclusive: accept needs an empty shadow, commit needs a full one.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      full     <= 1'b0;
      sh_bcd   <= '0;
      sh_dp    <= '0;
      disp_bcd <= '0;
      disp_dp  <= '0;
      BCD_ERR  <= 1'b0;
    end else if (commit) begin
      full     <= 1'b0;
      disp_bcd <= sh_bcd;
      disp_dp  <= sh_dp;
      BCD_ERR  <= sh_bad;
    end else if (accept) begin
      full     <= 1'b1;
      sh_bcd   <= BCD_IN;
      sh_dp    <= DP_IN;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      SEG <= apply_pol(SEG_OFF, SEG_ACTIVE_LOW);
      DP  <= SEG_ACTIVE_LOW;
      COM <= COM_OFF;
    end else if (phase == PHASE_ON && !sel_blank) begin
      SEG <= apply_pol(dec_seg, SEG_ACTIVE_LOW);
      DP  <= disp_dp[idx] ^ SEG_ACTIVE_LOW;
      COM <= com_onehot ^ COM_OFF;
    end else begin
      SEG <= apply_pol(SEG_OFF, SEG_ACTIVE_LOW);
      DP  <= SEG_ACTIVE_LOW;
      COM <= COM_OFF;
    end
  end

endmodule

// File: tb/tb_bcd_disp_scan.sv
// Randomized and directed bench for bcd_disp_scan against a frame-position reference model.
module tb_bcd_disp_scan;

  localparam int ND    = 4;
  localparam int SDIV  = 8;
  localparam int BLNK  = 2;
  localparam int FRAME = ND * SDIV;

  logic          CLK = 1'b0;
  logic          RES = 1'b1;
  logic [15:0]   BCD_IN = '0;
  logic [3:0]    DP_IN = '0;
  logic          LOAD_VALID = 1'b0;
  logic          LOAD_READY;
  logic [6:0]    SEG;
  logic          DP;
  logic [3:0]    COM;
  logic          BCD_ERR;

  int checks = 0;
  int errors = 0;

  bcd_disp_scan #(
    .DIGITS(ND), .SCAN_DIV(SDIV), .BLANK_CYC(BLNK),
    .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .RES(RES), .BCD_IN(BCD_IN), .DP_IN(DP_IN),
    .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .SEG(SEG), .DP(DP), .COM(COM), .BCD_ERR(BCD_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Segment masks built from the names of the lit segments.
  function automatic logic [6:0] lit_mask(input int v);
    string s;
    logic [6:0] m;
    case (v)
      0: s = "abcdef";  1: s = "bc";     2: s = "abdeg";   3: s = "abcdg";
      4: s = "bcfg";    5: s = "acdfg";  6: s = "acdefg";  7: s = "abc";
      8: s = "abcdefg"; 9: s = "abcdfg"; default: s = "g";
    endcase
    m = '0;
    for (int k = 0; k < s.len(); k++) m[s[k] - "a"] = 1'b1;
    return m;
  endfunction

  // Reference model: position in the frame is just elapsed cycles modulo the frame length.
  int          m_n = 0;
  logic        m_full = 1'b0;
  logic [15:0] m_sh = '0, m_disp = '0;
  logic [3:0]  m_shdp = '0, m_ddp = '0;
  logic        m_err = 1'b0;
  logic [3:0]  e_com = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;

  function automatic bit lz_blanked(input int d, input logic [15:0] v, input logic [3:0] dps);
`ifdef LEADING_ZERO_BLANK_EN
    return (d > 0) && ((v >> (4 * d)) == 16'd0) && !dps[d];
`else
    return (d < 0) && (v == dps);
`endif
  endfunction

  always @(posedge CLK or posedge RES) begin
    int p, d, c, nib;
    if (RES) begin
      m_n = 0; m_full = 0; m_sh = 0; m_shdp = 0; m_disp = 0; m_ddp = 0; m_err = 0;
      e_com = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      p = m_n % FRAME;
      d = p / SDIV;
      c = p % SDIV;
      nib = int'((m_disp >> (4 * d)) & 16'hF);
      if (c < BLNK || lz_blanked(d, m_disp, m_ddp)) begin
        e_com = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_com = ~(4'b0001 << d);
        e_seg = ~lit_mask(nib);
        e_dp  = ~m_ddp[d];
      end
      if (p == FRAME - 1 && m_full) begin
        m_disp = m_sh; m_ddp = m_shdp; m_full = 0;
        m_err = 0;
        for (int k = 0; k < ND; k++) if (((m_sh >> (4 * k)) & 16'hF) > 9) m_err = 1;
      end else if (LOAD_VALID && !m_full) begin
        m_sh = BCD_IN; m_shdp = DP_IN; m_full = 1;
      end
      m_n++;
    end
  end

  always @(negedge CLK) begin
    check("com", 32'(COM), 32'(e_com));
    check("seg", 32'(SEG), 32'(e_seg));
    check("dp", 32'(DP), 32'(e_dp));
    check("ready", 32'(LOAD_READY), 32'(!m_full));
    check("bcd_err", 32'(BCD_ERR), 32'(m_err));
  end

  task automatic load(input logic [15:0] b, input logic [3:0] dps);
    logic r;
    int g;
    @(negedge CLK); #1;
    LOAD_VALID = 1'b1; BCD_IN = b; DP_IN = dps;
    g = 0;
    do begin
      r = LOAD_READY;
      @(negedge CLK); #1;
      g++;
    end while (!r && g < 200);
    check("load_accept", 32'(r), 32'(1));
    LOAD_VALID = 1'b0;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!LOAD_READY && g < 200) begin
      @(negedge CLK); #1;
      g++;
    end
    check("ready_timeout", 32'(LOAD_READY), 32'(1));
  endtask

  task automatic wait_com(input logic [3:0] pat);
    int g = 0;
    do begin
      @(negedge CLK);
      g++;
    end while (COM !== pat && g < 80);
    check("com_seen", 32'(COM), 32'(pat));
  endtask

  initial begin
    int n3, n2, exp_n;
    repeat (2) @(negedge CLK);
    #1 RES = 1'b0;
    check("rst_com", 32'(COM), 32'h0000000F);
    check("rst_seg", 32'(SEG), 32'h0000007F);
    check("rst_ready", 32'(LOAD_READY), 32'(1));
    check("rst_err", 32'(BCD_ERR), 32'(0));
    wait_com(4'b1110);
    check("lit_zero", 32'(SEG), 32'(7'b1000000));

    repeat (10) @(negedge CLK);
    load(16'h1234, 4'b0010);
    check("ready_drop", 32'(LOAD_READY), 32'(0));
    wait_ready();
    wait_com(4'b1101);
    check("lit_3", 32'(SEG), 32'(7'b0110000));
    check("lit_dp1", 32'(DP), 32'(0));
    wait_com(4'b1110);
    check("lit_4", 32'(SEG), 32'(7'b0011001));

    load(16'h1111, 4'b0000);
    load(16'h2222, 4'b0000);
    wait_ready();
    wait_com(4'b1110);
    check("lit_2", 32'(SEG), 32'(7'b0100100));

    load(16'h00A5, 4'b0000);
    wait_ready();
    repeat (2) @(negedge CLK);
    check("lit_err_set", 32'(BCD_ERR), 32'(1));
    wait_com(4'b1101);
    check("lit_dash", 32'(SEG), 32'(7'b0111111));
    load(16'h0005, 4'b0000);
    wait_ready();
    repeat (2) @(negedge CLK);
    check("lit_err_clr", 32'(BCD_ERR), 32'(0));

    load(16'h1357, 4'b1111);
    repeat (3) @(negedge CLK);
    #1 RES = 1'b1;
    #1;
    check("mid_rst_com", 32'(COM), 32'h0000000F);
    check("mid_rst_seg", 32'(SEG), 32'h0000007F);
    check("mid_rst_ready", 32'(LOAD_READY), 32'(1));
    @(negedge CLK); #1 RES = 1'b0;
    wait_com(4'b1110);
    check("post_rst_zero", 32'(SEG), 32'(7'b1000000));

    load(16'h0050, 4'b0000);
    wait_ready();
    repeat (2) @(negedge CLK);
    n3 = 0; n2 = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge CLK);
      if (COM[3] == 1'b0) n3++;
      if (COM[2] == 1'b0) n2++;
    end
`ifdef LEADING_ZERO_BLANK_EN
    exp_n = 0;
`else
    exp_n = SDIV - BLNK;
`endif
    check("lzb_com3", 32'(n3), 32'(exp_n));
    check("lzb_com2", 32'(n2), 32'(exp_n));

    for (int k = 0; k < 1500; k++) begin
      @(negedge CLK); #1;
      LOAD_VALID = ($urandom_range(0, 3) == 0);
      BCD_IN = 16'($urandom);
      DP_IN = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        RES = 1'b1;
        @(negedge CLK); #1;
        RES = 1'b0;
      end
    end
    LOAD_VALID = 1'b0;
    repeat (2 * FRAME) @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
